// File: rtl/pattern_writer_if.sv
// Raster-in / pixel-out bundle for pattern_writer: position, write strobe,
// mode handshake and the delayed VRAM write stream.
interface pattern_writer_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 12
);
  logic [9:0]        hpos;
  logic [9:0]        vpos;
  logic [ADDR_W-1:0] wvaddr;
  logic              vwen;
  logic              mode_req;
  logic [1:0]        mode_sel;
  logic              mode_ack;
  logic [ADDR_W-1:0] wvaddr_out;
  logic              vwen_out;
  logic [PIX_W-1:0]  vdin;
  logic [7:0]        frame_cnt;

  modport master (
    output hpos, vpos, wvaddr, vwen, mode_req, mode_sel,
    input  mode_ack, wvaddr_out, vwen_out, vdin, frame_cnt
  );

  modport slave (
    input  hpos, vpos, wvaddr, vwen, mode_req, mode_sel,
    output mode_ack, wvaddr_out, vwen_out, vdin, frame_cnt
  );
endinterface

// File: rtl/pattern_writer.sv
// Test-pattern generator feeding a VRAM write port with a two-cycle pipeline.
// Define PATTERN_SCROLL_EN to make mode 3 a frame-scrolled version of the bars.
module pattern_writer #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int NUM_BARS  = 16,
  parameter int BAND_ROWS = 120,
  parameter int ADDR_W    = 19,
  parameter int PIX_W     = 12
) (
  input  logic             clk25M,
  input  logic             reset,
  pattern_writer_if.slave  bus
);

  localparam int C      = PIX_W / 3;
  localparam int B      = $clog2(NUM_BARS);
  localparam int COLS   = H_ACTIVE / NUM_BARS;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int LINE_W = (BAND_ROWS > 1) ? $clog2(BAND_ROWS) : 1;

  localparam logic [9:0]        H_END     = 10'(H_ACTIVE);
  localparam logic [9:0]        V_END     = 10'(V_ACTIVE);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(BAND_ROWS - 1);

  logic              in_line, active, frame_edge, line_end;
  logic [COL_W-1:0]  col_q, col_cur;
  logic [B-1:0]      bar_q, bar_cur;
  logic [LINE_W-1:0] line_q;
  logic [1:0]        band_q;
  logic [1:0]        mode_q, pend_sel;
  logic              pend_q, ack_q;
  logic [7:0]        frame_q;
  logic [ADDR_W-1:0] addr1, addr2;
  logic              wen1, wen2, act1, grid1;
  logic [B-1:0]      bar1;
  logic [1:0]        band1;
  logic [PIX_W-1:0]  pix, pix2;

  assign in_line    = bus.hpos < H_END;
  assign active     = in_line && (bus.vpos < V_END);
  assign frame_edge = (bus.hpos == 10'd0) && (bus.vpos == V_END);
  assign line_end   = (bus.hpos == H_END) && (bus.vpos < V_END);

  // Counters hold the position of the next pixel; masking keeps blanking at zero.
  assign col_cur = in_line ? col_q : '0;
  assign bar_cur = in_line ? bar_q : '0;

  always_ff @(posedge clk25M) begin
    if (reset || !in_line) begin
      col_q <= '0;
      bar_q <= '0;
    end else if (col_q == COL_LAST) begin
      col_q <= '0;
      bar_q <= bar_q + B'(1);
    end else begin
      col_q <= col_q + COL_W'(1);
    end
  end

  always_ff @(posedge clk25M) begin
    if (reset || frame_edge) begin
      line_q <= '0;
      band_q <= '0;
    end else if (line_end) begin
      if (line_q == LINE_LAST) begin
        line_q <= '0;
        band_q <= band_q + 2'd1;
      end else begin
        line_q <= line_q + LINE_W'(1);
      end
    end
  end

  // A request landing on the boundary cycle wins over any older pending one.
  always_ff @(posedge clk25M) begin
    if (reset) begin
      mode_q   <= '0;
      pend_q   <= 1'b0;
      pend_sel <= '0;
      ack_q    <= 1'b0;
      frame_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      if (frame_edge) begin
        frame_q <= frame_q + 8'd1;
        if (bus.mode_req) begin
          mode_q <= bus.mode_sel;
          pend_q <= 1'b0;
          ack_q  <= 1'b1;
        end else if (pend_q) begin
          mode_q <= pend_sel;
          pend_q <= 1'b0;
          ack_q  <= 1'b1;
        end
      end else if (bus.mode_req) begin
        pend_q   <= 1'b1;
        pend_sel <= bus.mode_sel;
      end
    end
  end

  function automatic logic [PIX_W-1:0] bar_color(input logic [B-1:0] bar, input logic [1:0] band);
    logic [B+C-1:0] scaled;
    logic [C-1:0]   i;
    logic [C-1:0]   z;
    scaled = {bar, {C{1'b0}}};
    i      = scaled[B +: C];
    z      = '0;
    case (band)
      2'd0:    bar_color = {i, z, z};
      2'd1:    bar_color = {z, i, z};
      2'd2:    bar_color = {z, z, i};
      default: bar_color = {i, i, i};
    endcase
  endfunction

  always_comb begin
    pix = '0;
    if (act1) begin
      case (mode_q)
        2'd0:    pix = bar_color(bar1, band1);
        2'd1:    pix = {PIX_W{bar1[0] ^ band1[0]}};
        2'd2:    pix = {PIX_W{grid1}};
        default: begin
`ifdef PATTERN_SCROLL_EN
          pix = bar_color(bar1 + frame_q[B-1:0], band1);
`else
          pix = '0;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk25M) begin
    if (reset) begin
      addr1 <= '0;
      wen1  <= 1'b0;
      act1  <= 1'b0;
      bar1  <= '0;
      band1 <= '0;
      grid1 <= 1'b0;
      addr2 <= '0;
      wen2  <= 1'b0;
      pix2  <= '0;
    end else begin
      addr1 <= bus.wvaddr;
      wen1  <= bus.vwen;
      act1  <= active;
      bar1  <= bar_cur;
      band1 <= band_q;
      grid1 <= (col_cur == '0) || (line_q == '0);
      addr2 <= addr1;
      wen2  <= wen1;
      pix2  <= pix;
    end
  end

  assign bus.wvaddr_out = addr2;
  assign bus.vwen_out   = wen2;
  assign bus.vdin       = pix2;
  assign bus.mode_ack   = ack_q;
  assign bus.frame_cnt  = frame_q;

endmodule

// File: tb/tb_pattern_writer.sv
// Randomized bench for pattern_writer on a shrunken raster, scored against an
// arithmetic model of the pattern rules (division/modulo on raster position).
module tb_pattern_writer;
  localparam int H  = 64;
  localparam int V  = 16;
  localparam int NB = 8;
  localparam int BR = 3;
  localparam int AW = 19;
  localparam int PW = 12;
  localparam int C  = PW / 3;
  localparam int W  = H / NB;
  localparam logic [PW-1:0] ONES = '1;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wen;
    logic [PW-1:0] pix;
  } exp_t;

  logic clk25M = 1'b0;
  logic reset  = 1'b1;
  always #20 clk25M = ~clk25M;

  pattern_writer_if #(.ADDR_W(AW), .PIX_W(PW)) bus_if ();

  pattern_writer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .NUM_BARS(NB), .BAND_ROWS(BR), .ADDR_W(AW), .PIX_W(PW)
  ) dut (
    .clk25M(clk25M),
    .reset (reset),
    .bus   (bus_if)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_mode, m_pend, m_pend_sel, m_frame;
  bit   exp_ack;
  int   ack_seen;

  function automatic logic [PW-1:0] color(int bar, int band);
    int i;
    i = bar * (1 << C) / NB;
    case (band)
      0:       return PW'(i << (2 * C));
      1:       return PW'(i << C);
      2:       return PW'(i);
      default: return PW'((i << (2 * C)) | (i << C) | i);
    endcase
  endfunction

  function automatic logic [PW-1:0] model_pix(int h, int v, int mode, int frame);
    int bar, col, line, band;
    if (h >= H || v >= V) return '0;
    bar  = h / W;
    col  = h % W;
    line = v % BR;
    band = (v / BR) % 4;
    case (mode)
      0:       return color(bar, band);
      1:       return (((bar ^ band) & 1) == 1) ? ONES : '0;
      2:       return (col == 0 || line == 0) ? ONES : '0;
      default: begin
`ifdef PATTERN_SCROLL_EN
        return color((bar + frame) % NB, band);
`else
        return (frame < 0) ? ONES : '0;
`endif
      end
    endcase
  endfunction

  // One raster cycle: drive, advance the model, then score the DUT.
  task automatic raster_cycle(input int h, input int v, input bit req, input int sel);
    exp_t e;
    bit   boundary;
    boundary         = (h == 0 && v == V);
    bus_if.hpos      = 10'(h);
    bus_if.vpos      = 10'(v);
    bus_if.wvaddr    = AW'($urandom);
    bus_if.vwen      = 1'($urandom_range(0, 1));
    bus_if.mode_req  = req;
    bus_if.mode_sel  = 2'(sel);
    exp_ack = 1'b0;
    if (boundary) begin
      m_frame = (m_frame + 1) % 256;
      if (req) begin
        m_mode = sel; m_pend = 0; exp_ack = 1'b1;
      end else if (m_pend != 0) begin
        m_mode = m_pend_sel; m_pend = 0; exp_ack = 1'b1;
      end
    end else if (req) begin
      m_pend = 1; m_pend_sel = sel;
    end
    e.addr = bus_if.wvaddr;
    e.wen  = bus_if.vwen;
    e.pix  = model_pix(h, v, m_mode, m_frame);
    exp_q.push_back(e);
    @(posedge clk25M); #1;
    bus_if.mode_req = 1'b0;
    if (bus_if.mode_ack === 1'b1) ack_seen++;
    checks++;
    if (bus_if.mode_ack !== exp_ack) begin
      errors++;
      $display("[TB] FAIL mode_ack h=%0d v=%0d: got %b expected %b", h, v, bus_if.mode_ack, exp_ack);
    end
    checks++;
    if (bus_if.frame_cnt !== 8'(m_frame)) begin
      errors++;
      $display("[TB] FAIL frame_cnt: got %0d expected %0d", bus_if.frame_cnt, m_frame);
    end
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      checks += 3;
      if (bus_if.wvaddr_out !== e.addr) begin
        errors++;
        $display("[TB] FAIL wvaddr_out: got %h expected %h", bus_if.wvaddr_out, e.addr);
      end
      if (bus_if.vwen_out !== e.wen) begin
        errors++;
        $display("[TB] FAIL vwen_out: got %b expected %b", bus_if.vwen_out, e.wen);
      end
      if (bus_if.vdin !== e.pix) begin
        errors++;
        $display("[TB] FAIL vdin (input h=%0d v=%0d lagged): got %h expected %h", h, v, bus_if.vdin, e.pix);
      end
    end
  endtask

  task automatic run_frame(input int r1_line, input int r1_sel, input int r2_line, input int r2_sel,
                           input bit bnd_req, input int bnd_sel);
    int rh;
    rh = $urandom_range(0, H - 1);
    raster_cycle(H, V, 1'b0, 0);
    for (int v = 0; v < V; v++) begin
      for (int h = 0; h <= H; h++) begin
        if (v == r1_line && h == rh)      raster_cycle(h, v, 1'b1, r1_sel);
        else if (v == r2_line && h == rh) raster_cycle(h, v, 1'b1, r2_sel);
        else                              raster_cycle(h, v, 1'b0, 0);
      end
    end
    raster_cycle(0, V, bnd_req, bnd_sel);
  endtask

  task automatic do_reset(input int h, input int v);
    exp_t z;
    reset           = 1'b1;
    bus_if.hpos     = 10'(h);
    bus_if.vpos     = 10'(v);
    bus_if.wvaddr   = AW'($urandom) | AW'(1);
    bus_if.vwen     = 1'b1;
    bus_if.mode_req = 1'b0;
    bus_if.mode_sel = 2'd0;
    @(posedge clk25M); #1;
    checks += 5;
    if (bus_if.vdin !== '0) begin errors++; $display("[TB] FAIL reset vdin: got %h expected 0", bus_if.vdin); end
    if (bus_if.vwen_out !== 1'b0) begin errors++; $display("[TB] FAIL reset vwen_out: got %b expected 0", bus_if.vwen_out); end
    if (bus_if.wvaddr_out !== '0) begin errors++; $display("[TB] FAIL reset wvaddr_out: got %h expected 0", bus_if.wvaddr_out); end
    if (bus_if.mode_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset mode_ack: got %b expected 0", bus_if.mode_ack); end
    if (bus_if.frame_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset frame_cnt: got %0d expected 0", bus_if.frame_cnt); end
    reset = 1'b0;
    m_mode = 0; m_pend = 0; m_pend_sel = 0; m_frame = 0;
    exp_q.delete();
    z.addr = '0; z.wen = 1'b0; z.pix = '0;
    exp_q.push_back(z);
  endtask

  task automatic test_reset();
    do_reset(5, 3);
  endtask

  task automatic test_bars();
    run_frame(-1, 0, -1, 0, 1'b0, 0);
    run_frame(-1, 0, -1, 0, 1'b0, 0);
  endtask

  task automatic test_modes();
    for (int sel = 1; sel <= 3; sel++) begin
      ack_seen = 0;
      run_frame($urandom_range(0, V - 1), sel, -1, 0, 1'b0, 0);
      checks++;
      if (ack_seen !== 1) begin
        errors++;
        $display("[TB] FAIL ack count mode %0d: got %0d expected 1", sel, ack_seen);
      end
      run_frame(-1, 0, -1, 0, 1'b0, 0);
    end
  endtask

  task automatic test_double_request();
    ack_seen = 0;
    run_frame(3, 2, 10, 1, 1'b0, 0);
    checks++;
    if (ack_seen !== 1) begin
      errors++;
      $display("[TB] FAIL double request acks: got %0d expected 1", ack_seen);
    end
    run_frame(-1, 0, -1, 0, 1'b0, 0);
  endtask

  task automatic test_boundary_request();
    ack_seen = 0;
    run_frame(-1, 0, -1, 0, 1'b1, 2);
    checks++;
    if (ack_seen !== 1) begin
      errors++;
      $display("[TB] FAIL boundary request acks: got %0d expected 1", ack_seen);
    end
    run_frame(-1, 0, -1, 0, 1'b0, 0);
  endtask

  task automatic test_frame_wrap();
    do_reset(H + 3, 2);
    for (int n = 1; n <= 256; n++) begin
      raster_cycle(0, V, 1'b0, 0);
      if (n == 255) begin
        checks++;
        if (bus_if.frame_cnt !== 8'd255) begin
          errors++;
          $display("[TB] FAIL frame_cnt at 255: got %0d expected 255", bus_if.frame_cnt);
        end
      end
    end
    checks++;
    if (bus_if.frame_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL frame_cnt wrap: got %0d expected 0", bus_if.frame_cnt);
    end
    raster_cycle(0, V, 1'b1, 3);
    run_frame(-1, 0, -1, 0, 1'b0, 0);
  endtask

  task automatic test_reset_pending();
    do_reset(H, V);
    raster_cycle(H, V, 1'b0, 0);
    for (int v = 0; v < 5; v++)
      for (int h = 0; h <= H; h++)
        raster_cycle(h, v, (v == 2 && h == 10), 2);
    do_reset(30, 5);
    ack_seen = 0;
    run_frame(-1, 0, -1, 0, 1'b0, 0);
    checks++;
    if (ack_seen !== 0) begin
      errors++;
      $display("[TB] FAIL ack after reset: got %0d expected 0", ack_seen);
    end
    run_frame(-1, 0, -1, 0, 1'b0, 0);
  endtask

  initial begin
    bus_if.hpos     = '0;
    bus_if.vpos     = '0;
    bus_if.wvaddr   = '0;
    bus_if.vwen     = 1'b0;
    bus_if.mode_req = 1'b0;
    bus_if.mode_sel = 2'd0;
    m_mode = 0; m_pend = 0; m_pend_sel = 0; m_frame = 0; ack_seen = 0;
    test_reset();
    test_bars();
    test_modes();
    test_double_request();
    test_boundary_request();
    test_frame_wrap();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pattern_writer.md
PATTERN_WRITER -- requirements
Module: pattern_writer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter NUM_BARS, default 16, vertical bars per line; H_ACTIVE divisible by NUM_BARS, NUM_BARS a power of two, 2..64.
REQ-004 SHALL have parameter BAND_ROWS, default 120, lines per horizontal colour band.
REQ-005 SHALL have parameter ADDR_W, default 19, VRAM address width.
REQ-006 SHALL have parameter PIX_W, default 12, pixel width; multiple of 3; C = PIX_W/3 bits per channel, {R,G,B} order.
REQ-007 SHALL have port clk25M, input, 1, pixel clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous, active-high.
REQ-009 SHALL have ports hpos and vpos, input, 10 each, current raster position.
REQ-010 SHALL have port wvaddr, input, ADDR_W, write address aligned with hpos/vpos.
REQ-011 SHALL have port vwen, input, 1, write enable aligned with hpos/vpos.
REQ-012 SHALL have port mode_req, input, 1, one-cycle mode-change request.
REQ-013 SHALL have port mode_sel, input, 2, requested mode, sampled with mode_req.
REQ-014 SHALL have port mode_ack, output, 1, one-cycle pulse when a new mode takes effect.
REQ-015 SHALL have ports wvaddr_out (ADDR_W), vwen_out (1) and vdin (PIX_W), outputs, aligned write address, enable and pixel data.
REQ-016 SHALL have port frame_cnt, output, 8, completed-frame counter.

Function
REQ-017 active SHALL be hpos<H_ACTIVE and vpos<V_ACTIVE; frame boundary SHALL be hpos==0 and vpos==V_ACTIVE.
REQ-018 A column counter SHALL count 0..H_ACTIVE/NUM_BARS-1 while hpos<H_ACTIVE and increment bar index on wrap; both SHALL be 0 whenever hpos>=H_ACTIVE; no divide/modulo on hpos.
REQ-019 A band counter SHALL count lines 0..BAND_ROWS-1 at hpos==H_ACTIVE with active vpos, incrementing band index mod 4 on wrap; both clear at frame boundary.
REQ-020 Intensity I SHALL be bar index scaled to C bits: bar*2^C/NUM_BARS, low bits zero-padded if NUM_BARS<2^C.
REQ-021 Mode 0 (bars) SHALL output band 0 {I,0,0}, band 1 {0,I,0}, band 2 {0,0,I}, band 3 {I,I,I}.
REQ-022 Mode 1 (checker) SHALL output all-ones when bar[0] XOR band[0] is 1, else zero.
REQ-023 Mode 2 (grid) SHALL output all-ones when column counter==0 or band line counter==0, else zero.
REQ-024 Mode 3 SHALL behave per Configuration.
REQ-025 vdin SHALL be zero for inactive positions.
REQ-026 wvaddr_out, vwen_out and vdin SHALL lag inputs by exactly 2 cycles; vwen passes unmodified, including when inactive.
REQ-027 mode_req SHALL latch mode_sel as pending; a later request before the boundary overwrites it.
REQ-028 At a frame boundary with pending set, the mode SHALL update, pending clear and mode_ack pulse the following cycle; a request on the boundary cycle itself SHALL apply at that boundary.
REQ-029 frame_cnt SHALL increment at each frame boundary, wrapping 255->0.

Reset
REQ-030 Reset SHALL clear all counters, pending, mode (to 0), frame_cnt, mode_ack, vwen_out, wvaddr_out and vdin to zero on the next edge; reset mid-frame discards pending requests and restarts counting from current hpos.

Configuration
REQ-031 With PATTERN_SCROLL_EN defined, mode 3 SHALL output mode 0 using bar index (bar+frame_cnt) mod NUM_BARS; without it, mode 3 SHALL output zero and mode_ack still pulse.

Verification
REQ-032 Mode 0, defaults, hpos=80 vpos=0 -> vdin=12'h200 two cycles later; hpos=639 vpos=479 -> 12'hFFF.
REQ-033 hpos=640 vpos=10 with vwen=1 -> vdin=0, vwen_out=1 after 2 cycles.
REQ-034 mode_req mode_sel=1 at vpos=100 -> mode unchanged until vpos=480 hpos=0, mode_ack single pulse next cycle; hpos=40 vpos=0 -> 12'hFFF.
REQ-035 Two requests (2 then 1) in one frame -> only mode 1 applied, one mode_ack.
REQ-036 256 frame boundaries -> frame_cnt returns to 0; with PATTERN_SCROLL_EN, mode 3, frame_cnt=1, hpos=0 vpos=0 -> 12'h100.
REQ-037 Reset asserted mid-line with pending request -> outputs zero next edge, no mode_ack at next boundary.
